// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - shared encodings for the multi-cycle RV32I controller
// Purpose: opcode constants, FSM state codes, opcode classes and datapath
//          select encodings shared by multicycle_control and opcode_classifier.
// Ports:   none (package).
package multicycle_ctrl_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // FSM state codes
  typedef logic [2:0] state_t;
  localparam state_t ST_FETCH  = 3'd0;
  localparam state_t ST_DECODE = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_MEM    = 3'd3;
  localparam state_t ST_WB     = 3'd4;
  localparam state_t ST_TRAP   = 3'd5;

  // Instruction class produced by the opcode classifier
  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_LUI,
    CLS_AUIPC
  } op_class_e;

  // alu_op
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;

  // pc_src
  localparam logic [1:0] PC_ALU   = 2'd0;
  localparam logic [1:0] PC_TGT   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // alu_src_a
  localparam logic [1:0] SRCA_OLDPC = 2'd0;
  localparam logic [1:0] SRCA_RS1   = 2'd1;
  localparam logic [1:0] SRCA_ZERO  = 2'd2;
  localparam logic [1:0] SRCA_PC    = 2'd3;

  // alu_src_b
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  // wb_sel
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MDR  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;

endpackage

// File: rtl/multicycle_control_opcode_classifier.sv
// rtl/multicycle_control_opcode_classifier.sv - combinational opcode to class decoder
// Purpose: maps IR[6:0] to an instruction class and a legal flag. The
//          extended opcodes (I-ALU/JAL/JALR/LUI/AUIPC) decode only when
//          SUPPORT_EXT is nonzero, otherwise they fall out as CLS_NONE.
// Ports:   opcode   in  7  IR[6:0]
//          op_class out    decoded class (CLS_NONE when unsupported)
//          legal    out 1  opcode is supported
module opcode_classifier
  import multicycle_ctrl_pkg::*;
#(
  parameter int SUPPORT_EXT = 1
) (
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic       legal
);

  localparam bit EXT = (SUPPORT_EXT != 0);

  always_comb begin
    op_class = CLS_NONE;
    case (opcode)
      OPC_R:      op_class = CLS_R;
      OPC_LOAD:   op_class = CLS_LOAD;
      OPC_STORE:  op_class = CLS_STORE;
      OPC_BRANCH: op_class = CLS_BRANCH;
      OPC_IALU:   op_class = EXT ? CLS_IALU  : CLS_NONE;
      OPC_JAL:    op_class = EXT ? CLS_JAL   : CLS_NONE;
      OPC_JALR:   op_class = EXT ? CLS_JALR  : CLS_NONE;
      OPC_LUI:    op_class = EXT ? CLS_LUI   : CLS_NONE;
      OPC_AUIPC:  op_class = EXT ? CLS_AUIPC : CLS_NONE;
      default:    op_class = CLS_NONE;
    endcase
    legal = (op_class != CLS_NONE);
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I control FSM with memory watchdog
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
//          driving datapath enables and selects; traps illegal opcodes and
//          memory accesses that exceed MEM_TIMEOUT cycles into TRAP.
// Ports:   clk, rst (sync, active-high), opcode[6:0], mem_ready (inputs)
//          mem_req, mem_we, iord, ir_write, mdr_write, pc_write,
//          pc_write_cond, pc_src[1:0], alu_src_a[1:0], alu_src_b[1:0],
//          alu_op[1:0], wb_sel[1:0], reg_write, instr_done,
//          illegal_op (sticky), bus_error (sticky) (outputs)
module multicycle_control
  import multicycle_ctrl_pkg::*;
#(
  parameter int SUPPORT_EXT = 1,
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       mdr_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] wb_sel,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       bus_error
);

  localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W+1)'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       wb_sel_q, wb_sel_d;
  logic             is_store_q, is_store_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  op_class_e        op_class;
  logic             op_legal;

  opcode_classifier #(
    .SUPPORT_EXT(SUPPORT_EXT)
  ) u_classifier (
    .opcode  (opcode),
    .op_class(op_class),
    .legal   (op_legal)
  );

  logic [TMO_W:0] tmo_next;
  logic           tmo_hit;

  assign tmo_next = {1'b0, tmo_cnt_q} + {{TMO_W{1'b0}}, 1'b1};
  // This wait cycle is the MEM_TIMEOUT-th consecutive one without mem_ready.
  // A mem_ready in the same cycle takes priority and completes the access.
  assign tmo_hit  = (MEM_TIMEOUT != 0) && !mem_ready && (tmo_next == TMO_LIMIT);

  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    wb_sel_d      = wb_sel_q;
    is_store_d    = is_store_q;
    illegal_d     = illegal_q;
    bus_err_d     = bus_err_q;

    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    alu_src_a     = SRCA_OLDPC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    wb_sel        = WB_ALU;
    reg_write     = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          // Latch IR and advance PC by 4 in the same cycle.
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          pc_src    = PC_ALU;
          alu_src_a = SRCA_PC;
          alu_src_b = SRCB_FOUR;
          alu_op    = ALU_ADD;
          state_d   = ST_DECODE;
        end else if (tmo_hit) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_next[TMO_W-1:0];
        end
      end

      ST_DECODE: begin
        if (op_legal) begin
          state_d = ST_EXEC;
        end else begin
          state_d   = ST_TRAP;
          illegal_d = 1'b1;
        end
      end

      ST_EXEC: begin
        wb_sel_d   = WB_ALU;
        is_store_d = 1'b0;
        state_d    = ST_WB;
        case (op_class)
          CLS_R: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_RS2;
            alu_op    = ALU_RFN;
          end
          CLS_IALU: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_IFN;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALU_ADD;
            is_store_d = (op_class == CLS_STORE);
            state_d    = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_src_a     = SRCA_RS1;
            alu_src_b     = SRCB_RS2;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = PC_TGT;
            instr_done    = 1'b1;
            state_d       = ST_FETCH;
          end
          CLS_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_TGT;
            wb_sel_d = WB_LINK;
          end
          CLS_JALR: begin
            alu_src_a = SRCA_RS1;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
            pc_write  = 1'b1;
            pc_src    = PC_JALR;
            wb_sel_d  = WB_LINK;
          end
          CLS_LUI: begin
            alu_src_a = SRCA_ZERO;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
          end
          CLS_AUIPC: begin
            alu_src_a = SRCA_OLDPC;
            alu_src_b = SRCB_IMM;
            alu_op    = ALU_ADD;
          end
          default: begin
            // Opcode changed to an unsupported one after DECODE.
            state_d   = ST_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end

      ST_MEM: begin
        // Address computation is held so the ALU result stays valid.
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_we    = is_store_q;
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          if (is_store_q) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            mdr_write = 1'b1;
            wb_sel_d  = WB_MDR;
            state_d   = ST_WB;
          end
        end else if (tmo_hit) begin
          state_d   = ST_TRAP;
          bus_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_next[TMO_W-1:0];
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        wb_sel     = wb_sel_q;
        state_d    = ST_FETCH;
      end

      ST_TRAP: begin
        state_d = ST_TRAP;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // The watchdog measures one access at a time.
    if (state_d != state_q) begin
      tmo_cnt_d = '0;
    end

    illegal_op = illegal_q;
    bus_error  = bus_err_q;

    // Reset silences every output, including the Mealy strobes.
    if (rst) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = PC_ALU;
      alu_src_a     = SRCA_OLDPC;
      alu_src_b     = SRCB_RS2;
      alu_op        = ALU_ADD;
      wb_sel        = WB_ALU;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      bus_error     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      tmo_cnt_q  <= '0;
      wb_sel_q   <= WB_ALU;
      is_store_q <= 1'b0;
      illegal_q  <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_cnt_q  <= tmo_cnt_d;
      wb_sel_q   <= wb_sel_d;
      is_store_q <= is_store_d;
      illegal_q  <= illegal_d;
      bus_err_q  <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;
    logic       bus_error;
  } ctl_t;

  // One clock cycle: inputs for that cycle and the outputs required in it.
  // sel picks the instance: 0 = ext on / timeout 4, 1 = ext off / timeout 16.
  typedef struct {
    bit         sel;
    logic       rst;
    logic [6:0] opc;
    logic       rdy;
    ctl_t       exp;
  } vec_t;

  localparam ctl_t Z = '0;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] LD_OP = 7'b0000011;
  localparam logic [6:0] ST_OP = 7'b0100011;
  localparam logic [6:0] BR_OP = 7'b1100011;
  localparam logic [6:0] IA_OP = 7'b0010011;
  localparam logic [6:0] JL_OP = 7'b1101111;
  localparam logic [6:0] JR_OP = 7'b1100111;
  localparam logic [6:0] LU_OP = 7'b0110111;
  localparam logic [6:0] AU_OP = 7'b0010111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rdy_a, rst_b, rdy_b;
  logic [6:0] op_a, op_b;

  logic       a_mem_req, a_mem_we, a_iord, a_ir_write, a_mdr_write, a_pc_write, a_pc_write_cond;
  logic [1:0] a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_wb_sel;
  logic       a_reg_write, a_instr_done, a_illegal_op, a_bus_error;
  logic       b_mem_req, b_mem_we, b_iord, b_ir_write, b_mdr_write, b_pc_write, b_pc_write_cond;
  logic [1:0] b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_wb_sel;
  logic       b_reg_write, b_instr_done, b_illegal_op, b_bus_error;

  ctl_t act_a, act_b;
  assign act_a = {a_mem_req, a_mem_we, a_iord, a_ir_write, a_mdr_write, a_pc_write, a_pc_write_cond,
                  a_pc_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_wb_sel,
                  a_reg_write, a_instr_done, a_illegal_op, a_bus_error};
  assign act_b = {b_mem_req, b_mem_we, b_iord, b_ir_write, b_mdr_write, b_pc_write, b_pc_write_cond,
                  b_pc_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_wb_sel,
                  b_reg_write, b_instr_done, b_illegal_op, b_bus_error};

  multicycle_control #(.SUPPORT_EXT(1), .MEM_TIMEOUT(4), .TMO_W(8)) dut_a (
    .clk(clk), .rst(rst_a), .opcode(op_a), .mem_ready(rdy_a),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .iord(a_iord), .ir_write(a_ir_write),
    .mdr_write(a_mdr_write), .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond),
    .pc_src(a_pc_src), .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
    .wb_sel(a_wb_sel), .reg_write(a_reg_write), .instr_done(a_instr_done),
    .illegal_op(a_illegal_op), .bus_error(a_bus_error)
  );

  multicycle_control #(.SUPPORT_EXT(0), .MEM_TIMEOUT(16), .TMO_W(8)) dut_b (
    .clk(clk), .rst(rst_b), .opcode(op_b), .mem_ready(rdy_b),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .iord(b_iord), .ir_write(b_ir_write),
    .mdr_write(b_mdr_write), .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond),
    .pc_src(b_pc_src), .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
    .wb_sel(b_wb_sel), .reg_write(b_reg_write), .instr_done(b_instr_done),
    .illegal_op(b_illegal_op), .bus_error(b_bus_error)
  );

  vec_t  vq[$];
  string tq[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  logic [6:0] ops [9] = '{R_OP, LD_OP, ST_OP, BR_OP, IA_OP, JL_OP, JR_OP, LU_OP, AU_OP};

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic add(input bit sel, input logic r, input logic [6:0] o, input logic rd,
                     input ctl_t e, input string t);
    vec_t v;
    v.sel = sel; v.rst = r; v.opc = o; v.rdy = rd; v.exp = e;
    vq.push_back(v);
    tq.push_back(t);
  endtask

  task automatic chk(input ctl_t act, input ctl_t exp, input string t, input int i,
                     input string which);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s (vec %0d, dut_%s): outputs=%h required=%h", t, i, which, act, exp);
    end
  endtask

  // ---------------- behavioural reference: per-phase output rules ----------
  function automatic bit is_legal(logic [6:0] o, int ext);
    if (o inside {R_OP, LD_OP, ST_OP, BR_OP}) return 1'b1;
    if (ext != 0 && (o inside {IA_OP, JL_OP, JR_OP, LU_OP, AU_OP})) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ctl_t e_fetch(logic rdy);
    ctl_t e = '0;
    e.mem_req = 1'b1;
    if (rdy) begin
      e.ir_write = 1'b1; e.pc_write = 1'b1;
      e.alu_src_a = 2'd3; e.alu_src_b = 2'd2;
    end
    return e;
  endfunction

  // nxt: 0 = write back, 1 = memory access, 2 = retires in EXEC
  function automatic ctl_t e_exec(logic [6:0] o, output logic [1:0] wbs, output int nxt);
    ctl_t e = '0;
    wbs = 2'd0;
    nxt = 0;
    case (o)
      R_OP:         begin e.alu_src_a = 2'd1; e.alu_op = 2'b10; end
      IA_OP:        begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.alu_op = 2'b11; end
      LD_OP, ST_OP: begin e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; nxt = 1; end
      BR_OP: begin
        e.alu_src_a = 2'd1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
        e.pc_src = 2'd1; e.instr_done = 1'b1; nxt = 2;
      end
      JL_OP: begin e.pc_write = 1'b1; e.pc_src = 2'd1; wbs = 2'd2; end
      JR_OP: begin
        e.alu_src_a = 2'd1; e.alu_src_b = 2'd1; e.pc_write = 1'b1; e.pc_src = 2'd2; wbs = 2'd2;
      end
      LU_OP:   begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
      AU_OP:   begin e.alu_src_b = 2'd1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic ctl_t e_mem(logic rdy, bit store);
    ctl_t e = '0;
    e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = store;
    e.alu_src_a = 2'd1; e.alu_src_b = 2'd1;
    if (rdy) begin
      if (store) e.instr_done = 1'b1;
      else       e.mdr_write  = 1'b1;
    end
    return e;
  endfunction

  function automatic ctl_t e_wb(logic [1:0] wbs);
    ctl_t e = '0;
    e.reg_write = 1'b1; e.instr_done = 1'b1; e.wb_sel = wbs;
    return e;
  endfunction

  // Schedules one whole instruction: fw / mw are the number of cycles
  // mem_ready stays low in fetch / memory. An access that waits tmo cycles
  // (tmo != 0) traps; a trap is held for tail cycles then cleared by rst.
  task automatic gen_instr(input bit sel, input logic [6:0] opc, input int fw, input int mw,
                           input int ext, input int tmo, input int tail, input string tag);
    ctl_t       e;
    logic [1:0] wbs;
    int         nxt;
    bit         store = (opc == ST_OP);
    bit         bus = 1'b0;
    bit         ill = 1'b0;
    for (int w = 1; w <= fw && !bus; w++) begin
      add(sel, 1'b0, rnd7(), 1'b0, e_fetch(1'b0), {tag, "/fetch_wait"});
      if (tmo != 0 && w == tmo) bus = 1'b1;
    end
    if (!bus) begin
      add(sel, 1'b0, rnd7(), 1'b1, e_fetch(1'b1), {tag, "/fetch"});
      add(sel, 1'b0, opc, rbit(), Z, {tag, "/decode"});
      if (!is_legal(opc, ext)) begin
        ill = 1'b1;
      end else begin
        e = e_exec(opc, wbs, nxt);
        add(sel, 1'b0, opc, rbit(), e, {tag, "/exec"});
        if (nxt == 1) begin
          for (int w = 1; w <= mw && !bus; w++) begin
            add(sel, 1'b0, rnd7(), 1'b0, e_mem(1'b0, store), {tag, "/mem_wait"});
            if (tmo != 0 && w == tmo) bus = 1'b1;
          end
          if (!bus) begin
            add(sel, 1'b0, rnd7(), 1'b1, e_mem(1'b1, store), {tag, "/mem"});
            if (store) nxt = 2;
            else begin wbs = 2'd1; nxt = 0; end
          end
        end
        if (!bus && nxt == 0) add(sel, 1'b0, rnd7(), rbit(), e_wb(wbs), {tag, "/wb"});
      end
    end
    if (bus || ill) begin
      e = '0;
      e.illegal_op = ill;
      e.bus_error  = bus;
      for (int k = 0; k < tail; k++) add(sel, 1'b0, rnd7(), rbit(), e, {tag, "/trap"});
      add(sel, 1'b1, rnd7(), rbit(), Z, {tag, "/trap_rst"});
    end
  endtask

  // ---------------- test ---------------------------------------------------
  initial begin
    logic [6:0] opc;
    int         fw, mw;
    ctl_t       ew;

    rst_a = 1'b1; rst_b = 1'b1; op_a = '0; op_b = '0; rdy_a = 1'b0; rdy_b = 1'b0;

    #1;
    chk(act_a, Z, "reset_state_a", -1, "a");
    chk(act_b, Z, "reset_state_b", -1, "b");

    // Reset: outputs silent even with mem_ready high.
    add(0, 1'b1, R_OP, 1'b1, Z, "reset_a");
    add(0, 1'b1, ST_OP, 1'b1, Z, "reset_a");

    // R-type, mem_ready high every cycle: four cycles, done only in WB.
    add(0, 1'b0, R_OP, 1'b1, '{mem_req:1'b1, ir_write:1'b1, pc_write:1'b1,
        alu_src_a:2'd3, alu_src_b:2'd2, default:'0}, "rtype_fetch");
    add(0, 1'b0, R_OP, 1'b1, Z, "rtype_decode");
    add(0, 1'b0, R_OP, 1'b1, '{alu_src_a:2'd1, alu_op:2'b10, default:'0}, "rtype_exec");
    add(0, 1'b0, R_OP, 1'b1, '{reg_write:1'b1, instr_done:1'b1, default:'0}, "rtype_wb");

    // Store with one wait cycle in MEM, then back to FETCH.
    add(0, 1'b0, ST_OP, 1'b1, '{mem_req:1'b1, ir_write:1'b1, pc_write:1'b1,
        alu_src_a:2'd3, alu_src_b:2'd2, default:'0}, "store_fetch");
    add(0, 1'b0, ST_OP, 1'b0, Z, "store_decode");
    add(0, 1'b0, ST_OP, 1'b0, '{alu_src_a:2'd1, alu_src_b:2'd1, default:'0}, "store_exec");
    add(0, 1'b0, 7'h00, 1'b0, '{mem_req:1'b1, mem_we:1'b1, iord:1'b1,
        alu_src_a:2'd1, alu_src_b:2'd1, default:'0}, "store_mem_wait");
    add(0, 1'b0, 7'h7f, 1'b1, '{mem_req:1'b1, mem_we:1'b1, iord:1'b1,
        alu_src_a:2'd1, alu_src_b:2'd1, instr_done:1'b1, default:'0}, "store_mem");
    add(0, 1'b0, ST_OP, 1'b0, '{mem_req:1'b1, default:'0}, "store_next_fetch");
    add(0, 1'b0, ST_OP, 1'b1, '{mem_req:1'b1, ir_write:1'b1, pc_write:1'b1,
        alu_src_a:2'd3, alu_src_b:2'd2, default:'0}, "store_next_fetch_rdy");
    add(0, 1'b0, BR_OP, 1'b1, Z, "branch_decode");
    add(0, 1'b0, BR_OP, 1'b1, '{alu_src_a:2'd1, alu_op:2'b01, pc_write_cond:1'b1,
        pc_src:2'd1, instr_done:1'b1, default:'0}, "branch_exec");

    // Load with mem_ready three cycles late: 8 cycles total.
    gen_instr(0, LD_OP, 0, 3, 1, 4, 0, "load_late");
    gen_instr(0, JL_OP, 0, 0, 1, 4, 0, "jal_ext");
    gen_instr(0, JR_OP, 1, 0, 1, 4, 0, "jalr_ext");
    // Watchdog: ready exactly on the limit cycle completes; stuck low traps.
    gen_instr(0, R_OP, 3, 0, 1, 4, 0, "fetch_at_limit");
    gen_instr(0, LD_OP, 3, 3, 1, 4, 0, "mem_at_limit");
    gen_instr(0, R_OP, 4, 0, 1, 4, 6, "fetch_timeout");
    gen_instr(0, ST_OP, 0, 5, 1, 4, 3, "mem_timeout");
    gen_instr(0, 7'b1111111, 0, 0, 1, 4, 3, "illegal_a");

    // rst during a store's MEM cycle: no mem_we / instr_done, then FETCH.
    add(0, 1'b0, ST_OP, 1'b1, e_fetch(1'b1), "rst_store_fetch");
    add(0, 1'b0, ST_OP, 1'b1, Z, "rst_store_decode");
    add(0, 1'b0, ST_OP, 1'b1, '{alu_src_a:2'd1, alu_src_b:2'd1, default:'0}, "rst_store_exec");
    add(0, 1'b1, ST_OP, 1'b1, Z, "rst_store_mem");
    add(0, 1'b0, ST_OP, 1'b0, '{mem_req:1'b1, default:'0}, "rst_store_after");
    // rst during JAL's EXEC: no pc_write.
    add(0, 1'b0, JL_OP, 1'b1, e_fetch(1'b1), "rst_jal_fetch");
    add(0, 1'b0, JL_OP, 1'b1, Z, "rst_jal_decode");
    add(0, 1'b1, JL_OP, 1'b1, Z, "rst_jal_exec");
    add(0, 1'b0, JL_OP, 1'b0, '{mem_req:1'b1, default:'0}, "rst_jal_after");
    // rst during a load's WB: no reg_write.
    add(0, 1'b0, LD_OP, 1'b1, e_fetch(1'b1), "rst_ld_fetch");
    add(0, 1'b0, LD_OP, 1'b1, Z, "rst_ld_decode");
    add(0, 1'b0, LD_OP, 1'b1, '{alu_src_a:2'd1, alu_src_b:2'd1, default:'0}, "rst_ld_exec");
    add(0, 1'b0, LD_OP, 1'b1, e_mem(1'b1, 1'b0), "rst_ld_mem");
    add(0, 1'b1, LD_OP, 1'b1, Z, "rst_ld_wb");
    add(0, 1'b0, LD_OP, 1'b0, '{mem_req:1'b1, default:'0}, "rst_ld_after");
    add(0, 1'b1, LD_OP, 1'b0, Z, "rst_ld_clear");

    // Randomized instruction stream on the extended instance.
    for (int i = 0; i < 150; i++) begin
      int pick = $urandom_range(0, 9);
      opc = (pick == 9) ? rnd7() : ops[pick];
      fw  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      mw  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      gen_instr(0, opc, fw, mw, 1, 4, $urandom_range(1, 4), "rand");
    end

    // Base-only instance, default watchdog of 16.
    add(1, 1'b1, JL_OP, 1'b1, Z, "reset_b");
    gen_instr(1, JL_OP, 0, 0, 0, 16, 20, "jal_noext");
    gen_instr(1, IA_OP, 0, 0, 0, 16, 2, "ialu_noext");
    gen_instr(1, R_OP, 0, 0, 0, 16, 0, "rtype_b");
    gen_instr(1, LD_OP, 15, 15, 0, 16, 0, "b_at_limit");
    gen_instr(1, ST_OP, 16, 0, 0, 16, 4, "b_timeout");
    for (int i = 0; i < 30; i++) begin
      int pick = $urandom_range(0, 8);
      gen_instr(1, ops[pick], $urandom_range(0, 3), $urandom_range(0, 3), 0, 16, 2, "rand_b");
    end

    // Apply: inputs change just after the rising edge, outputs are sampled
    // on the falling edge of the same cycle.
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk);
      #1;
      if (vq[i].sel == 1'b0) begin
        rst_a = vq[i].rst; op_a = vq[i].opc; rdy_a = vq[i].rdy;
        rst_b = 1'b1;      op_b = rnd7();    rdy_b = rbit();
      end else begin
        rst_b = vq[i].rst; op_b = vq[i].opc; rdy_b = vq[i].rdy;
        rst_a = 1'b1;      op_a = rnd7();    rdy_a = rbit();
      end
      @(negedge clk);
      chk(vq[i].sel ? act_b : act_a, vq[i].exp, tq[i], i, vq[i].sel ? "b" : "a");
    end

    // Expired wait on dut_a: mem_ready stuck low in FETCH, timeout 4.
    @(posedge clk);
    #1;
    rst_a = 1'b1; op_a = R_OP; rdy_a = 1'b0;
    rst_b = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      rst_a = 1'b0; op_a = rnd7(); rdy_a = 1'b0;
      @(negedge clk);
      ew = '0;
      if (c <= 4) ew.mem_req   = 1'b1;
      else        ew.bus_error = 1'b1;
      chk(act_a, ew, "expired_wait", c, "a");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- Sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB states and drives datapath enables, mux selects and ALU op class.
- Handles a memory ready handshake with a watchdog timeout.
- Adds I-ALU, JAL, JALR, LUI and AUIPC support, gated by a parameter. Sits between the instruction register and the shared multi-cycle datapath.

Parameters:
SUPPORT_EXT, 1, 1 = decode I-ALU/JAL/JALR/LUI/AUIPC; 0 = those opcodes are illegal.
MEM_TIMEOUT, 16, max cycles waiting for mem_ready per access; 0 disables the watchdog.
TMO_W, 8, watchdog counter width; must satisfy MEM_TIMEOUT < 2**TMO_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
opcode  in  7  IR[6:0]; valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write strobe (store only)
iord  out  1  address select: 0 = PC, 1 = ALU result
ir_write  out  1  latch instruction
mdr_write  out  1  latch load data
pc_write  out  1  unconditional PC update
pc_write_cond  out  1  PC update if ALU zero
pc_src  out  2  0 = ALU result, 1 = branch/JAL target adder, 2 = ALU result (JALR, LSB cleared by datapath)
alu_src_a  out  2  0 = old_pc, 1 = rs1, 2 = zero, 3 = pc
alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
alu_op  out  2  00 = add, 01 = sub, 10 = R funct, 11 = I funct
wb_sel  out  2  0 = ALU out, 1 = MDR, 2 = link (old_pc+4)
reg_write  out  1  register file write
instr_done  out  1  one-cycle pulse on the final cycle of each instruction
illegal_op  out  1  sticky: unsupported opcode trapped
bus_error  out  1  sticky: memory timeout trapped

Behaviour:
- Controller type: Moore FSM plus a mem_ready-qualified Mealy strobe. States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding goes in the package.
- Reset: state <= FETCH, watchdog counter <= 0, sticky flags <= 0. While rst=1, all outputs are 0.
- Default outputs are 0 in every state. Only the listed signals are asserted.
- FETCH: mem_req=1, iord=0.
  - When mem_ready=1: ir_write=1, pc_write=1, pc_src=0, alu_src_a=3, alu_src_b=2, alu_op=00; go to DECODE.
- DECODE: no strobes, 1 cycle.
  - Legal opcode: go to EXEC.
  - Otherwise: go to TRAP and set illegal_op.
  - Legal set:
    - Always: 0110011, 0000011, 0100011, 1100011.
    - When SUPPORT_EXT=1, also: 0010011, 1101111, 1100111, 0110111, 0010111.
- EXEC, by opcode:
  - R-type: a=1, b=0, op=10; go to WB, wb_sel=0.
  - I-ALU: a=1, b=1, op=11; go to WB, wb_sel=0.
  - LOAD/STORE: a=1, b=1, op=00; go to MEM.
  - BRANCH: a=1, b=0, op=01, pc_write_cond=1, pc_src=1, instr_done=1; go to FETCH.
  - JAL: pc_write=1, pc_src=1; go to WB, wb_sel=2.
  - JALR: a=1, b=1, op=00, pc_write=1, pc_src=2; go to WB, wb_sel=2.
  - LUI: a=2, b=1, op=00; go to WB, wb_sel=0.
  - AUIPC: a=0, b=1, op=00; go to WB, wb_sel=0.
- MEM: mem_req=1, iord=1, mem_we=1 for store only. Hold a=1, b=1, op=00 throughout.
  - mem_ready=1 on a store: instr_done=1; go to FETCH.
  - mem_ready=1 on a load: mdr_write=1; go to WB, wb_sel=1.
- WB: reg_write=1, instr_done=1, wb_sel as chosen in EXEC (registered); go to FETCH.
- TRAP: absorbing state; only illegal_op/bus_error are high. Exit by rst only.
- Watchdog:
  - Counter clears on every state entry and increments each cycle spent in FETCH/MEM with mem_ready=0.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready=0: go to TRAP and set bus_error.
  - mem_ready in the same cycle as the limit wins; the access completes normally.
- Opcode is sampled in DECODE and EXEC only; changes elsewhere are ignored.
- rst mid-instruction aborts it in the next cycle and returns to FETCH; no partial reg_write or PC strobe is emitted.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - opcode constants;
  - state enum;
  - alu_op, pc_src, alu_src_a/b and wb_sel encodings.
- One sub-module, opcode_classifier: combinational opcode to class plus legal flag, honouring SUPPORT_EXT.
- The FSM and watchdog stay in the top module.

Test Plan:
- R-type 0110011, mem_ready=1 every cycle: 4 cycles FETCH→DECODE→EXEC→WB; reg_write and instr_done high only in cycle 4; alu_op=10 in EXEC.
- Load 0000011 with mem_ready delayed 3 cycles in MEM: mem_req/iord held 4 cycles; mdr_write pulses once; WB has wb_sel=1 and reg_write=1; total 8 cycles.
- Store 0100011: mem_we=1 only in MEM; no reg_write; instr_done on the mem_ready cycle; next state FETCH.
- JAL 1101111 with SUPPORT_EXT=1: EXEC has pc_write=1, pc_src=1; WB has wb_sel=2. With SUPPORT_EXT=0: illegal_op set after DECODE, TRAP held 20 cycles, cleared by rst.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH: bus_error asserts on cycle 5, all strobes 0 afterward. Repeat with mem_ready=1 exactly at the limit: no error.
- rst asserted in the MEM cycle of a store: mem_we=0 next cycle; state FETCH; outputs all 0 while rst=1.
